// File: rtl/imm_encoder_pkg.sv
// Shared immediate-type encodings and range limits, used by both the
// immediate encoder and the decode-side sign extender.
package imm_encoder_pkg;

    typedef enum logic [2:0] {
        EXT_I   = 3'b000,
        EXT_B   = 3'b001,
        EXT_JAL = 3'b010,
        EXT_U   = 3'b011,
        EXT_S   = 3'b110
    } imm_type_e;

    // Inclusive signed byte-offset limits per format
    localparam int IMM_IS_MIN = -2048;
    localparam int IMM_IS_MAX = 2047;
    localparam int IMM_B_MIN  = -4096;
    localparam int IMM_B_MAX  = 4094;
    localparam int IMM_J_MIN  = -1048576;
    localparam int IMM_J_MAX  = 1048574;

    function automatic logic ext_type_known(input logic [2:0] t);
        return t inside {EXT_I, EXT_B, EXT_JAL, EXT_U, EXT_S};
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational immediate placement into an instruction template, plus
// optional range/alignment checking (enabled by IMM_ENC_RANGE_CHECK_EN).
module imm_pack
    import imm_encoder_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [31:0] imm,
    input  logic [31:0] base,
    output logic [31:0] instr,
    output logic        err
);

    logic range_err;

    always_comb begin
        instr = base;
        case (kind)
            EXT_I: instr[31:20] = imm[11:0];
            EXT_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
            end
            EXT_B: begin
                instr[31]    = imm[12];
                instr[7]     = imm[11];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
            end
            EXT_U: instr[31:12] = imm[31:12];
            EXT_JAL: begin
                instr[31]    = imm[20];
                instr[30:21] = imm[10:1];
                instr[20]    = imm[11];
                instr[19:12] = imm[19:12];
            end
            default: ;
        endcase
    end

`ifdef IMM_ENC_RANGE_CHECK_EN
    always_comb begin
        range_err = 1'b0;
        case (kind)
            EXT_I, EXT_S: range_err = ($signed(imm) < IMM_IS_MIN) || ($signed(imm) > IMM_IS_MAX);
            EXT_B:        range_err = ($signed(imm) < IMM_B_MIN) || ($signed(imm) > IMM_B_MAX) || imm[0];
            EXT_JAL:      range_err = ($signed(imm) < IMM_J_MIN) || ($signed(imm) > IMM_J_MAX) || imm[0];
            EXT_U:        range_err = (imm[11:0] != 12'd0);
            default:      range_err = 1'b0;
        endcase
    end
`else
    // Out-of-range values are silently truncated to the placed bits
    assign range_err = 1'b0;
`endif

    assign err = !ext_type_known(kind) || range_err;

endmodule

// File: rtl/imm_encoder.sv
// Two-stage immediate encoder: S1 captures the request, S2 registers the
// encoded instruction. Range checking follows IMM_ENC_RANGE_CHECK_EN.
module imm_encoder
    import imm_encoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_type,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_base,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic        out_err,
    input  logic        err_clr,
    output logic        err_sticky,
    output logic [15:0] pkt_cnt
);

    logic        s1_valid;
    logic [2:0]  s1_type;
    logic [31:0] s1_imm;
    logic [31:0] s1_base;
    logic [31:0] pack_instr;
    logic        pack_err;
    logic        s2_adv;
    logic        out_hs;

    // S2 can take a new beat when empty or draining this cycle
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_adv;
    assign out_hs   = out_valid && out_ready;

    imm_pack u_pack (
        .kind  (s1_type),
        .imm   (s1_imm),
        .base  (s1_base),
        .instr (pack_instr),
        .err   (pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_type  <= 3'd0;
            s1_imm   <= 32'd0;
            s1_base  <= 32'd0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_type <= in_type;
                s1_imm  <= in_imm;
                s1_base <= in_base;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_instr <= 32'd0;
            out_err   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_instr <= pack_instr;
                out_err   <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt    <= 16'd0;
            err_sticky <= 1'b0;
        end else begin
            if (out_hs) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
            // A new error beat outranks a simultaneous clear
            if (out_hs && out_err) begin
                err_sticky <= 1'b1;
            end else if (err_clr) begin
                err_sticky <= 1'b0;
            end
        end
    end

endmodule
